bcd_alarm_clock_core: RTL

//  Timekeeping core of the alarm clock: BCD HH:MM time counter, alarm register, set-mode editing
//  and alarm ring state machine. disp_bcd feeds the 4-digit 7-segment encoder stage directly
//  (nibble order {H tens, H units, M tens, M units}). Buttons arrive pre-debounced, 1-cycle pulses.

---
 rtl/bcd_alarm_clock_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_alarm_clock_core.sv
// BCD HH:MM alarm clock core: time/alarm registers, set-mode editing and alarm ring FSM.
// Optional snooze support is compiled in when the SNOOZE_EN macro is defined.
module bcd_alarm_clock_core #(
    parameter int SEC_PER_MIN = 60,
    parameter int RING_MIN    = 5,
    parameter int SNOOZE_MIN  = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_tick,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        inc_hour,
    input  logic        inc_min,
    input  logic        alarm_en,
    input  logic        alarm_stop,
    input  logic        snooze,
    output logic [15:0] time_bcd,
    output logic [15:0] disp_bcd,
    output logic        alarm_ring,
    output logic        colon
);

    localparam int SEC_W   = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam int CNT_MAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RINGING,
        ST_SNOOZED
    } alarm_state_e;

    function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
        if (m[3:0] == 4'd9) begin
            return (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'h0};
        end
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_hour_inc(input logic [7:0] h);
        if (h == 8'h23) begin
            return 8'h00;
        end
        if (h[3:0] == 4'd9) begin
            return {h[7:4] + 4'd1, 4'h0};
        end
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [15:0]      time_q, time_d;
    logic [15:0]      alarm_q, alarm_d;
    logic [15:0]      disp_q, disp_d;
    logic             colon_q, colon_d;
    logic             minute_roll;

    alarm_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             alarm_ring_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sec_d       = sec_q;
        time_d      = time_q;
        alarm_d     = alarm_q;
        minute_roll = 1'b0;

        if (set_time) begin
            sec_d = '0;
            if (inc_hour) time_d[15:8] = bcd_hour_inc(time_q[15:8]);
            if (inc_min)  time_d[7:0]  = bcd_min_inc(time_q[7:0]);
        end else begin
            if (sec_tick) begin
                if (sec_q == SEC_W'(SEC_PER_MIN - 1)) begin
                    sec_d        = '0;
                    minute_roll  = 1'b1;
                    time_d[7:0]  = bcd_min_inc(time_q[7:0]);
                    if (time_q[7:0] == 8'h59) time_d[15:8] = bcd_hour_inc(time_q[15:8]);
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end
            // Alarm edits run alongside a still-ticking time of day.
            if (set_alarm) begin
                if (inc_hour) alarm_d[15:8] = bcd_hour_inc(alarm_q[15:8]);
                if (inc_min)  alarm_d[7:0]  = bcd_min_inc(alarm_q[7:0]);
            end
        end

        if (set_time || set_alarm) begin
            colon_d = 1'b1;
        end else begin
            colon_d = sec_tick ? ~colon_q : colon_q;
        end

        disp_d = (set_alarm && !set_time) ? alarm_d : time_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= '0;
            time_q  <= 16'h0000;
            alarm_q <= 16'h0700;
            disp_q  <= 16'h0000;
            colon_q <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            time_q  <= time_d;
            alarm_q <= alarm_d;
            disp_q  <= disp_d;
            colon_q <= colon_d;
        end
    end

    // cnt_q counts minute rollovers spent in RINGING or SNOOZED; it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alarm_ring_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alarm_en && minute_roll && (time_d == alarm_q)) begin
                        state_q      <= ST_RINGING;
                        cnt_q        <= '0;
                        alarm_ring_q <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (alarm_stop || !alarm_en) begin
                        state_q      <= ST_IDLE;
                        alarm_ring_q <= 1'b0;
`ifdef SNOOZE_EN
                    end else if (snooze) begin
                        state_q      <= ST_SNOOZED;
                        cnt_q        <= '0;
                        alarm_ring_q <= 1'b0;
`endif
                    end else if (minute_roll) begin
                        if (cnt_q == CNT_W'(RING_MIN - 1)) begin
                            state_q      <= ST_IDLE;
                            alarm_ring_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_SNOOZED: begin
`ifdef SNOOZE_EN
                    if (alarm_stop || !alarm_en) begin
                        state_q      <= ST_IDLE;
                        alarm_ring_q <= 1'b0;
                    end else if (minute_roll) begin
                        if (cnt_q == CNT_W'(SNOOZE_MIN - 1)) begin
                            state_q      <= ST_RINGING;
                            cnt_q        <= '0;
                            alarm_ring_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`else
                    state_q      <= ST_IDLE;
                    alarm_ring_q <= 1'b0;
`endif
                end
                default: begin
                    state_q      <= ST_IDLE;
                    alarm_ring_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign time_bcd   = time_q;
    assign disp_bcd   = disp_q;
    assign alarm_ring = alarm_ring_q;
    assign colon      = colon_q;

endmodule
